// File: rtl/docita_mem_pkg.sv
// rtl/docita_mem_pkg.sv - shared widths and FSM encoding for the DOCITA memory subsystem
package docita_mem_pkg;
  localparam int WORD_W = 12;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;
endpackage

// File: rtl/docita_sram.sv
// rtl/docita_sram.sv - single-port word array, synchronous write, registered read, no reset
module docita_sram
  import docita_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  // rdata only moves on a read, so it naturally holds between reads
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/docita_memsys.sv
// rtl/docita_memsys.sv - CPU program/data memory with sequential host loader and CPU reset hold
module docita_memsys
  import docita_mem_pkg::*;
#(
  parameter int DEPTH    = 4096,
  parameter int HOLD_CYC = 4
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  input  logic [ADDR_W-1:0] iCPU_ADDR,
  input  logic [WORD_W-1:0] iCPU_DATA,
  input  logic              iCPU_CSELn,
  input  logic              iCPU_WR_ENn,
  output logic [WORD_W-1:0] oCPU_DATA,
  output logic              oCPU_RESETn,
  input  logic              iHOST_START,
  input  logic              iHOST_VALID,
  input  logic [WORD_W-1:0] iHOST_DATA,
  input  logic              iHOST_LAST,
  output logic              oHOST_READY,
  output logic [CNT_W-1:0]  oLOAD_CNT,
  output logic [WORD_W-1:0] oCHECKSUM,
  output logic              oLOAD_ERR
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

  state_t            state, state_nxt;
  logic [3:0]        hold_cnt;
  logic              rd_vld;
  logic              accept, overflow, cpu_act;
  logic              mem_we, mem_re;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata, mem_rdata;

  assign oHOST_READY = (state == ST_LOAD);
  assign oCPU_RESETn = (state == ST_RUN);
  assign accept      = iHOST_VALID & oHOST_READY;
  assign overflow    = (oLOAD_CNT == FULL);
  // a START edge drops any CPU access that coincides with it
  assign cpu_act     = (state == ST_RUN) & ~iHOST_START & ~iCPU_CSELn;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_LOAD;
      ST_LOAD: if (accept && iHOST_LAST) state_nxt = ST_HOLD;
      ST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
    if (iHOST_START) state_nxt = ST_LOAD;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = iCPU_ADDR[AW-1:0];
    mem_wdata = iCPU_DATA;
    if (oHOST_READY) begin
      mem_we    = accept & ~iHOST_START & ~overflow;
      mem_addr  = oLOAD_CNT[AW-1:0];
      mem_wdata = iHOST_DATA;
    end else begin
      mem_we = cpu_act & ~iCPU_WR_ENn;
      mem_re = cpu_act & iCPU_WR_ENn;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      oLOAD_CNT <= '0;
      oCHECKSUM <= '0;
      oLOAD_ERR <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + 4'd1 : 4'd0;
      if (iHOST_START) begin
        oLOAD_CNT <= '0;
        oCHECKSUM <= '0;
        oLOAD_ERR <= 1'b0;
      end else if (accept) begin
        if (overflow) begin
          oLOAD_ERR <= 1'b1;
        end else begin
          oLOAD_CNT <= oLOAD_CNT + 1'b1;
          oCHECKSUM <= oCHECKSUM + iHOST_DATA;
        end
      end
      // read data is exposed only while the CPU owns the array
      if (state_nxt != ST_RUN) rd_vld <= 1'b0;
      else if (mem_re)         rd_vld <= 1'b1;
    end
  end

  assign oCPU_DATA = rd_vld ? mem_rdata : '0;

  docita_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (iCLK),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_docita_memsys.sv
// tb/tb_docita_memsys.sv - directed self-checking bench for docita_memsys
module tb_docita_memsys;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cpu_addr, cpu_wdata, host_data;
  logic        cpu_cseln, cpu_wrn, host_start, host_valid, host_last;

  logic [11:0] rdata, rdata8, csum, csum8;
  logic        cpu_rstn, cpu_rstn8, ready, ready8, err, err8;
  logic [12:0] cnt, cnt8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  docita_memsys #(.DEPTH(4096), .HOLD_CYC(4)) dut (
    .iCLK(clk), .iRESETn(rst_n),
    .iCPU_ADDR(cpu_addr), .iCPU_DATA(cpu_wdata), .iCPU_CSELn(cpu_cseln), .iCPU_WR_ENn(cpu_wrn),
    .oCPU_DATA(rdata), .oCPU_RESETn(cpu_rstn),
    .iHOST_START(host_start), .iHOST_VALID(host_valid), .iHOST_DATA(host_data), .iHOST_LAST(host_last),
    .oHOST_READY(ready), .oLOAD_CNT(cnt), .oCHECKSUM(csum), .oLOAD_ERR(err)
  );

  docita_memsys #(.DEPTH(8), .HOLD_CYC(4)) dut8 (
    .iCLK(clk), .iRESETn(rst_n),
    .iCPU_ADDR(cpu_addr), .iCPU_DATA(cpu_wdata), .iCPU_CSELn(cpu_cseln), .iCPU_WR_ENn(cpu_wrn),
    .oCPU_DATA(rdata8), .oCPU_RESETn(cpu_rstn8),
    .iHOST_START(host_start), .iHOST_VALID(host_valid), .iHOST_DATA(host_data), .iHOST_LAST(host_last),
    .oHOST_READY(ready8), .oLOAD_CNT(cnt8), .oCHECKSUM(csum8), .oLOAD_ERR(err8)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [11:0] a);
    cpu_cseln = 1'b0; cpu_wrn = 1'b1; cpu_addr = a;
    tick();
    cpu_cseln = 1'b1;
  endtask

  task automatic wait_run(input string tag);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk(tag, 16'(cpu_rstn), 16'(k == 4));
    end
  endtask

  initial begin
    rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_cseln = 1'b1; cpu_wrn = 1'b1;
    host_start = 1'b0; host_valid = 1'b0; host_data = '0; host_last = 1'b0;
    #12;
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_cpurst", 16'(cpu_rstn), 16'd0);
    chk("rst_cnt", 16'(cnt), 16'd0);
    chk("rst_rdata", 16'(rdata), 16'd0);
    rst_n = 1'b1;
    tick();
    chk("load_ready", 16'(ready), 16'd1);

    host_valid = 1'b1; host_data = 12'o1234; tick();
    host_data = 12'o0007; tick();
    host_data = 12'o7777; host_last = 1'b1; tick();
    host_valid = 1'b0; host_last = 1'b0;
    chk("last_ready", 16'(ready), 16'd0);
    chk("load_cnt", 16'(cnt), 16'd3);
    chk("load_csum", 16'(csum), 16'o1242);
    chk("hold_rdata", 16'(rdata), 16'd0);
    wait_run("hold_release");

    cpu_read(12'o0001);
    chk("rd_a1", 16'(rdata), 16'o0007);

    cpu_cseln = 1'b0; cpu_wrn = 1'b0; cpu_addr = 12'o0100; cpu_wdata = 12'o5555; tick();
    cpu_wrn = 1'b1; tick(); cpu_cseln = 1'b1;
    chk("wr_rd_100", 16'(rdata), 16'o5555);

    cpu_wrn = 1'b0; cpu_wdata = 12'o3333; tick();
    cpu_wrn = 1'b1;
    chk("desel_hold", 16'(rdata), 16'o5555);
    cpu_read(12'o0100);
    chk("desel_nowr", 16'(rdata), 16'o5555);

    // START together with a CPU write that must be dropped
    host_start = 1'b1; cpu_cseln = 1'b0; cpu_wrn = 1'b0; cpu_addr = 12'o0001; cpu_wdata = 12'o4444;
    tick();
    host_start = 1'b0; cpu_cseln = 1'b1; cpu_wrn = 1'b1;
    chk("st_cpurst", 16'(cpu_rstn), 16'd0);
    chk("st_ready", 16'(ready), 16'd1);
    chk("st_cnt", 16'(cnt), 16'd0);
    chk("st_csum", 16'(csum), 16'd0);
    chk("st_rdata", 16'(rdata), 16'd0);
    host_valid = 1'b1; host_data = 12'o0001; host_last = 1'b1; tick();
    host_valid = 1'b0; host_last = 1'b0;
    chk("reload_cnt", 16'(cnt), 16'd1);
    chk("reload_csum", 16'(csum), 16'd1);
    wait_run("reload_release");
    cpu_read(12'o0000);
    chk("reload_m0", 16'(rdata), 16'o0001);
    cpu_read(12'o0001);
    chk("reload_m1", 16'(rdata), 16'o0007);

    // overflow on the DEPTH=8 instance, no overflow on the big one
    host_start = 1'b1; tick(); host_start = 1'b0;
    host_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      host_data = 12'o0100 + 12'(i);
      tick();
    end
    chk("ovf_err8", 16'(err8), 16'd1);
    chk("ovf_cnt8", 16'(cnt8), 16'd8);
    chk("ovf_csum8", 16'(csum8), 16'd540);
    chk("ovf_err", 16'(err), 16'd0);
    chk("ovf_cnt", 16'(cnt), 16'd9);
    host_data = 12'o7000; host_last = 1'b1; tick();
    host_valid = 1'b0; host_last = 1'b0;
    chk("ovf_last_cnt8", 16'(cnt8), 16'd8);
    chk("ovf_last_ready8", 16'(ready8), 16'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("ovf_run8", 16'(cpu_rstn8), 16'd1);
    cpu_read(12'o0000);
    chk("ovf_m0_8", 16'(rdata8), 16'o0100);
    chk("ovf_m0", 16'(rdata), 16'o0100);

    // reset in the middle of a load, away from any clock edge
    host_start = 1'b1; tick(); host_start = 1'b0;
    host_valid = 1'b1; host_data = 12'o2222; tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 16'(ready), 16'd0);
    chk("mid_rst_cnt", 16'(cnt), 16'd0);
    chk("mid_rst_csum", 16'(csum), 16'd0);
    chk("mid_rst_cpurst", 16'(cpu_rstn), 16'd0);
    host_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 16'(ready), 16'd1);
    host_valid = 1'b1; host_data = 12'o0005; host_last = 1'b1; tick();
    host_valid = 1'b0; host_last = 1'b0;
    wait_run("post_rst_release");
    cpu_read(12'o0000);
    chk("post_rst_m0", 16'(rdata), 16'o0005);
    cpu_read(12'o0001);
    chk("post_rst_m1", 16'(rdata), 16'o0101);
    cpu_read(12'o0100);
    chk("post_rst_m100", 16'(rdata), 16'o5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/docita_memsys.md
# docita_memsys

Program/data memory subsystem sitting directly downstream of the DOCITA CPU's memory bus. It holds a single-port 12-bit word array that the CPU reads and writes through its chip-select/write-enable strobes. A host load port fills the array sequentially from address 0 while the CPU is held in reset. The CPU is released after the last word is loaded plus a fixed hold time.

## Interface
- `DEPTH`, 4096: number of 12-bit words; must be a power of two, 2..4096.
- `HOLD_CYC`, 4: cycles the CPU stays in reset after the last load word; must be 1..15.
- `iCLK` in 1: system clock; all state changes on the rising edge.
- `iRESETn` in 1: asynchronous, active-low reset.
- `iCPU_ADDR` in 12: CPU word address. Only the low log2(DEPTH) bits are used, so the array aliases.
- `iCPU_DATA` in 12: CPU write data.
- `iCPU_CSELn` in 1: CPU chip select, active low.
- `iCPU_WR_ENn` in 1: CPU write enable, active low; qualified by `iCPU_CSELn`.
- `oCPU_DATA` out 12: registered read data to the CPU.
- `oCPU_RESETn` out 1: drives the CPU's `iRESETn`.
- `iHOST_START` in 1: one-cycle pulse that restarts loading.
- `iHOST_VALID` in 1: load word valid.
- `iHOST_DATA` in 12: load word.
- `iHOST_LAST` in 1: marks the final load word.
- `oHOST_READY` out 1: load port accepts a word.
- `oLOAD_CNT` out 13: number of words written in the current load.
- `oCHECKSUM` out 12: sum mod 4096 of the words written.
- `oLOAD_ERR` out 1: sticky overflow flag.

## Operation
- States:
  - IDLE: after reset.
  - LOAD: accepting host words.
  - HOLD: counting out the hold time.
  - RUN: CPU owns the array.
- Transitions:
  - IDLE→LOAD unconditionally.
  - LOAD→HOLD on an accepted word with `iHOST_LAST`=1.
  - HOLD→RUN after `HOLD_CYC` cycles.
  - `iHOST_START` in LOAD, HOLD or RUN → LOAD.
- Register outputs and state:
  - `oHOST_READY` is 1 only in LOAD.
  - `oCPU_RESETn` is 1 only in RUN.
- LOAD:
  - Word accept = `iHOST_VALID` & `oHOST_READY`.
  - On accept: write `iHOST_DATA` to mem[ptr], then ptr+1, `oLOAD_CNT`+1, `oCHECKSUM` += word (mod 4096).
  - CPU strobes are ignored and `oCPU_DATA` is held at 0.
- Entering LOAD via `iHOST_START`: ptr, `oLOAD_CNT`, `oCHECKSUM` and `oLOAD_ERR` are cleared to 0.
- Start vs. word: if `iHOST_START` coincides with an accept, start wins and the word is discarded.
- Overflow: an accepted word when `oLOAD_CNT`=DEPTH is discarded and sets `oLOAD_ERR`.
  - The counter and checksum stay unchanged.
  - If that word carries LAST, the FSM still goes to HOLD.
- Empty load (LAST with `oLOAD_CNT`=0) writes mem[0] normally.
- RUN:
  - `iCPU_CSELn`=0 & `iCPU_WR_ENn`=0: write `iCPU_DATA` to mem[addr].
  - `iCPU_CSELn`=0 & `iCPU_WR_ENn`=1: `oCPU_DATA` ← mem[addr].
  - `iCPU_CSELn`=1: no access; `oCPU_DATA` holds, even if `iCPU_WR_ENn`=0.
- HOLD: no array access; `oCPU_DATA` holds 0.
- Memory contents are not reset and are never cleared by START.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - `oCPU_RESETn`=0, `oHOST_READY`=0, `oCPU_DATA`=0, `oLOAD_CNT`=0, `oCHECKSUM`=0, `oLOAD_ERR`=0.
- First rising edge after reset deassertion: LOAD, so `oHOST_READY`=1.
- Load throughput: one word per cycle, no back-pressure inside LOAD.
- LAST accepted at edge N:
  - `oHOST_READY`=0 after N.
  - `oCPU_RESETn`=1 after edge N+`HOLD_CYC`.
- Read latency: one cycle. Address sampled at edge N; data valid after N, held until the next read.
- Write: takes effect at the sampling edge. A read of the same address at the next edge returns the new data.
- `iHOST_START` at edge N:
  - `oCPU_RESETn`=0 and `oHOST_READY`=1 after N.
  - An in-flight CPU access at N is dropped.
- Reset asserted mid-LOAD or mid-RUN:
  - All outputs return to reset values immediately.
  - Array contents are retained.

## Structure
- Shared package `docita_mem_pkg` holds:
  - state encoding (IDLE/LOAD/HOLD/RUN, 2 bits);
  - word width 12;
  - CPU address width 12;
  - count width 13.
- Sub-module `docita_sram`: single-port DEPTH×12 array with synchronous write and registered read, no reset.
  - The top level muxes address and data between the host pointer (LOAD) and the CPU port (RUN).
  - The two ports are never active together.
- Top level contains the FSM, the hold counter, the pointer/count/checksum/error registers and the port muxing.

## Test plan
- Reset, then load 0o1234, 0o0007, 0o7777 (LAST on the third) on consecutive cycles.
  - Expect `oLOAD_CNT`=3 and `oCHECKSUM`=0o1242.
  - `oCPU_RESETn` rises exactly 4 edges after the LAST accept.
- RUN read, address 1: `oCPU_DATA`=0o0007 one cycle later.
- RUN write then read: write 0o5555 to 0o100, read 0o100 on the next cycle → 0o5555.
- `iCPU_CSELn`=1 with `iCPU_WR_ENn`=0 and data 0o3333 at 0o100:
  - `oCPU_DATA` holds.
  - A later read of 0o100 returns 0o5555.
- `iHOST_START` in RUN:
  - Next edge: `oCPU_RESETn`=0, `oHOST_READY`=1, count and checksum 0.
  - Reload 0o0001 with LAST → mem[0]=0o0001, mem[1] still 0o0007.
- DEPTH=8, 9 words without LAST:
  - `oLOAD_ERR`=1 and `oLOAD_CNT`=8.
  - The 9th word is not written; mem[0] is unchanged.
- Reset mid-LOAD:
  - Outputs return to reset values with no clock edge.
  - After reset, previously loaded words are readable once a new LAST-only load completes.
